// File: rtl/spi_param_regbank.sv
// SPI register bank: command word then unbounded data burst with auto-increment, flop registers plus RO status words.
// Latency: write commits on the last data bit edge; readback MSB is on serial_out right after the command/word edge.
module spi_param_regbank #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int NUM_REGS  = 8,
  parameter int BASE_ADDR = 60,
  parameter int NUM_RO    = 1,
  parameter int AUTO_INC  = 1
) (
  input  logic                         sclk,
  input  logic                         rstn,
  input  logic                         cs_n,
  input  logic                         serial_in,
  input  logic [NUM_RO*DATA_W-1:0]     ro_data,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_stb,
  output logic                         serial_out,
  output logic                         addr_err
);

  localparam int AW       = ADDR_W - 1;
  localparam int BITS_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W    = $clog2(BITS_MAX);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [AW-1:0]    FIRST_ADDR = AW'(BASE_ADDR);
  localparam logic [AW-1:0]    LAST_ADDR  = AW'(BASE_ADDR + NUM_REGS + NUM_RO - 1);

  if (BASE_ADDR + NUM_REGS + NUM_RO > 2**(ADDR_W-1)) begin : g_map_check
    $error("spi_param_regbank: register map does not fit in the address space");
  end

  typedef enum logic {S_CMD, S_DATA} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt;
  logic [AW-1:0]           cmd_sr;
  logic [DATA_W-2:0]       wr_sr;
  logic [DATA_W-1:0]       rd_sr;
  logic                    rw_q;
  logic [AW-1:0]           addr_q;
  logic [DATA_W-1:0]       regs [NUM_REGS];

  logic                    cmd_done, word_done;
  logic                    cmd_rw;
  logic [AW-1:0]           cmd_addr;
  logic [DATA_W-1:0]       wr_word;
  logic [AW-1:0]           addr_nxt;
  logic [NUM_REGS-1:0]     wr_hit;
  logic                    frame_rst_n;

  // Framing state is cleared by either reset or an idle chip select.
  assign frame_rst_n = rstn & ~cs_n;

  function automatic logic [DATA_W-1:0] word_at(input logic [AW-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(a) == 32'(BASE_ADDR + i)) w = regs[i];
    for (int i = 0; i < NUM_RO; i++)
      if (32'(a) == 32'(BASE_ADDR + NUM_REGS + i)) w = ro_data[i*DATA_W +: DATA_W];
    return w;
  endfunction

  function automatic logic is_mapped(input logic [AW-1:0] a);
    return (32'(a) >= 32'(BASE_ADDR)) && (32'(a) < 32'(BASE_ADDR + NUM_REGS + NUM_RO));
  endfunction

  assign cmd_rw   = cmd_sr[AW-1];
  assign cmd_addr = {cmd_sr[AW-2:0], serial_in};
  assign wr_word  = {wr_sr, serial_in};

  always_comb begin
    addr_nxt = addr_q;
    if (AUTO_INC != 0)
      addr_nxt = (addr_q == LAST_ADDR) ? FIRST_ADDR : addr_q + 1'b1;
  end

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_hit[i] = word_done && rw_q && (32'(addr_q) == 32'(BASE_ADDR + i));
  end

  always_ff @(posedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) state_q <= S_CMD;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_done  = 1'b0;
    word_done = 1'b0;
    case (state_q)
      S_CMD: begin
        if (bit_cnt == CMD_LAST) begin
          cmd_done = 1'b1;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        word_done = (bit_cnt == DATA_LAST);
      end
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      bit_cnt <= '0;
      cmd_sr  <= '0;
      wr_sr   <= '0;
      rd_sr   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
    end else if (state_q == S_CMD) begin
      cmd_sr <= cmd_addr;
      if (cmd_done) begin
        bit_cnt <= '0;
        rw_q    <= cmd_rw;
        addr_q  <= cmd_addr;
        rd_sr   <= word_at(cmd_addr);
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else begin
      wr_sr <= wr_word[DATA_W-2:0];
      if (word_done) begin
        bit_cnt <= '0;
        addr_q  <= addr_nxt;
        // Reload reads pre-commit register values, so a write burst echoes old contents.
        rd_sr   <= word_at(addr_nxt);
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        rd_sr   <= {rd_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign serial_out = rd_sr[DATA_W-1];

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_stb   <= '0;
      addr_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_hit[i]) regs[i] <= wr_word;
      wr_stb <= wr_hit;
      if ((cmd_done && !is_mapped(cmd_addr)) || (word_done && !is_mapped(addr_q)))
        addr_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_spi_param_regbank.sv
// Directed bench for spi_param_regbank: drives SPI frames on negedge, samples serial_out and strobes on negedge.
module tb_spi_param_regbank;

  logic        sclk = 1'b0;
  logic        rstn;
  logic        cs_n;
  logic        serial_in;
  logic [7:0]  ro_data;
  logic [63:0] reg_q;
  logic [7:0]  wr_stb;
  logic        serial_out;
  logic        addr_err;

  spi_param_regbank dut (
    .sclk       (sclk),
    .rstn       (rstn),
    .cs_n       (cs_n),
    .serial_in  (serial_in),
    .ro_data    (ro_data),
    .reg_q      (reg_q),
    .wr_stb     (wr_stb),
    .serial_out (serial_out),
    .addr_err   (addr_err)
  );

  always #5 sclk = ~sclk;

  int n_chk = 0;
  int n_err = 0;
  int stb_n [8];
  int stb_base [8];

  always @(negedge sclk)
    for (int i = 0; i < 8; i++)
      if (wr_stb[i]) stb_n[i] = stb_n[i] + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int stb_delta(input int i);
    return stb_n[i] - stb_base[i];
  endfunction

  function automatic int stb_total();
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += stb_n[i] - stb_base[i];
    return s;
  endfunction

  // Entered and left on a negedge; the posedge in between samples each bit.
  task automatic xfer(input logic [7:0] din, input int nbits, output logic [7:0] dout);
    dout = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      serial_in = din[i];
      dout[i]   = serial_out;
      @(negedge sclk);
    end
  endtask

  task automatic frame_begin();
    for (int i = 0; i < 8; i++) stb_base[i] = stb_n[i];
    cs_n = 1'b0;
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    serial_in = 1'b0;
    repeat (2) @(negedge sclk);
  endtask

  logic [7:0]  d;
  logic [7:0]  exp_rd [4];
  logic [63:0] exp_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; cs_n = 1'b1; serial_in = 1'b0; ro_data = 8'h01;
    repeat (3) @(negedge sclk);
    check("rst_reg_q", reg_q, 64'h0);
    check("rst_wr_stb", {56'h0, wr_stb}, 64'h0);
    check("rst_serial_out", {63'h0, serial_out}, 64'h0);
    check("rst_addr_err", {63'h0, addr_err}, 64'h0);
    rstn = 1'b1;
    @(negedge sclk);

    // Single write to addr 60
    frame_begin();
    xfer(8'hBC, 8, d);
    xfer(8'hA5, 8, d);
    check("t1_readback", {56'h0, d}, 64'h00);
    frame_end();
    exp_q = 64'h0000_0000_0000_00A5;
    check("t1_reg_q", reg_q, exp_q);
    check("t1_stb0", 64'(stb_delta(0)), 64'd1);
    check("t1_stb_total", 64'(stb_total()), 64'd1);

    // Burst from addr 67: reg7, RO word (ignored), wrap to reg0
    frame_begin();
    xfer(8'hC3, 8, d);
    xfer(8'h11, 8, d);
    check("t2_rd_reg7", {56'h0, d}, 64'h00);
    xfer(8'h22, 8, d);
    check("t2_rd_ro", {56'h0, d}, 64'h01);
    xfer(8'h33, 8, d);
    check("t2_rd_reg0_prewrite", {56'h0, d}, 64'hA5);
    frame_end();
    exp_q = 64'h1100_0000_0000_0033;
    check("t2_reg_q", reg_q, exp_q);
    check("t2_stb7", 64'(stb_delta(7)), 64'd1);
    check("t2_stb_total", 64'(stb_total()), 64'd2);
    check("t2_addr_err", {63'h0, addr_err}, 64'h0);

    // Preload regs 0,1 then read 4 words from addr 60
    frame_begin();
    xfer(8'hBC, 8, d);
    xfer(8'h5A, 8, d);
    xfer(8'h3C, 8, d);
    frame_end();
    exp_q = 64'h1100_0000_0000_3C5A;
    check("t3_preload", reg_q, exp_q);
    exp_rd[0] = 8'h5A; exp_rd[1] = 8'h3C; exp_rd[2] = 8'h00; exp_rd[3] = 8'h00;
    frame_begin();
    xfer(8'h3C, 8, d);
    for (int k = 0; k < 4; k++) begin
      xfer(8'h00, 8, d);
      check($sformatf("t3_rd%0d", k), {56'h0, d}, {56'h0, exp_rd[k]});
    end
    frame_end();
    check("t3_stb_total", 64'(stb_total()), 64'd0);
    check("t3_reg_q", reg_q, exp_q);

    // Unmapped write to addr 5
    frame_begin();
    xfer(8'h85, 8, d);
    xfer(8'hFF, 8, d);
    check("t4_readback", {56'h0, d}, 64'h00);
    frame_end();
    check("t4_reg_q", reg_q, exp_q);
    check("t4_stb_total", 64'(stb_total()), 64'd0);
    check("t4_addr_err", {63'h0, addr_err}, 64'h1);

    // Abort after 4 data bits, then a clean write to addr 61
    frame_begin();
    xfer(8'hBE, 8, d);
    xfer(8'hF0, 4, d);
    frame_end();
    check("t5_abort_reg_q", reg_q, exp_q);
    check("t5_abort_stb", 64'(stb_total()), 64'd0);
    check("t5_serial_out_idle", {63'h0, serial_out}, 64'h0);
    frame_begin();
    xfer(8'hBD, 8, d);
    xfer(8'h77, 8, d);
    check("t5_readback", {56'h0, d}, 64'h3C);
    frame_end();
    exp_q = 64'h1100_0000_0000_775A;
    check("t5_reg_q", reg_q, exp_q);
    check("t5_stb1", 64'(stb_delta(1)), 64'd1);
    check("t5_stb_total", 64'(stb_total()), 64'd1);
    check("t5_addr_err_sticky", {63'h0, addr_err}, 64'h1);

    // Reset during the second word of a burst
    frame_begin();
    xfer(8'hBE, 8, d);
    xfer(8'h12, 8, d);
    check("t6_reg2_written", reg_q, 64'h1100_0000_0012_775A);
    xfer(8'h34, 4, d);
    rstn = 1'b0;
    #1;
    check("t6_rst_reg_q", reg_q, 64'h0);
    check("t6_rst_serial_out", {63'h0, serial_out}, 64'h0);
    check("t6_rst_addr_err", {63'h0, addr_err}, 64'h0);
    check("t6_rst_wr_stb", {56'h0, wr_stb}, 64'h0);
    @(negedge sclk);
    cs_n = 1'b1;
    rstn = 1'b1;
    repeat (2) @(negedge sclk);
    frame_begin();
    xfer(8'hBF, 8, d);
    xfer(8'h99, 8, d);
    check("t6_readback", {56'h0, d}, 64'h00);
    frame_end();
    check("t6_reg_q", reg_q, 64'h0000_0000_9900_0000);
    check("t6_stb3", 64'(stb_delta(3)), 64'd1);
    check("t6_stb_total", 64'(stb_total()), 64'd1);
    check("t6_addr_err", {63'h0, addr_err}, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
